// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo Philips I2S transmitter with a frame FIFO.
// Define I2S_TX_HOLD_LAST_EN to resend the last frame on underrun.
module i2s_tx_fifo #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int DEPTH    = 8,
  parameter int SCLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_left,
  input  logic [DATA_W-1:0]          s_right,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       underrun,
  input  logic                       underrun_clr,
  output logic                       sclk,
  output logic                       lrclk,
  output logic                       sdout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(2*SLOT_W);

  localparam logic [DW-1:0] D_LAST = DW'(SCLK_DIV-1);
  localparam logic [DW-1:0] D_HALF = DW'(SCLK_DIV/2);
  localparam logic [BW-1:0] B_LAST = BW'(2*SLOT_W-1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_W);
  localparam logic [BW-1:0] B_DATA = BW'(DATA_W);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] mem_l [DEPTH];
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [BW-1:0]     pos;
  logic [DATA_W-1:0] fr_l, fr_r, fr_l_n, fr_r_n;
  logic [DATA_W-1:0] word, mask;
  logic              push, pop, load, empty, urun_set;
  logic              sclk_n, lrclk_n, sdout_n;

  assign s_ready = (level != L_FULL);
  assign empty   = (level == '0);
  assign push    = s_valid && s_ready;

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    bcnt_n  = bcnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = RUN;
          dcnt_n  = '0;
          bcnt_n  = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        dcnt_n = (dcnt == D_LAST) ? '0 : dcnt + 1'b1;
        if (dcnt == D_LAST) begin
          bcnt_n = (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
          if (bcnt == B_LAST) begin
            if (enable) load = 1'b1;
            else state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they track counters.
  always_comb begin
    pop      = load && !empty;
    urun_set = load && empty;
    fr_l_n   = fr_l;
    fr_r_n   = fr_r;
    if (pop) begin
      fr_l_n = mem_l[rptr];
      fr_r_n = mem_r[rptr];
    end else if (urun_set && !HOLD) begin
      fr_l_n = '0;
      fr_r_n = '0;
    end
    lrclk_n = (bcnt_n >= B_SLOT);
    pos     = lrclk_n ? bcnt_n - B_SLOT : bcnt_n;
    word    = lrclk_n ? fr_r_n : fr_l_n;
    mask    = DATA_W'(1) << (B_DATA - pos);
    sdout_n = (pos != '0) && (pos <= B_DATA)
              && (|(word & mask));
    sclk_n  = (dcnt_n >= D_HALF);
    if (state_n == IDLE) begin
      sclk_n  = 1'b0;
      lrclk_n = 1'b0;
      sdout_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_l[wptr] <= s_left;
      mem_r[wptr] <= s_right;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default: ;
      endcase
      underrun <= urun_set | (underrun & ~underrun_clr);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      dcnt  <= '0;
      bcnt  <= '0;
      fr_l  <= '0;
      fr_r  <= '0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
      sdout <= 1'b0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      bcnt  <= bcnt_n;
      fr_l  <= fr_l_n;
      fr_r  <= fr_r_n;
      sclk  <= sclk_n;
      lrclk <= lrclk_n;
      sdout <= sdout_n;
    end
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: random frames checked against a queue model and a
// line decoder that rebuilds frames from sclk/lrclk/sdout.
`timescale 1ns/1ps
module tb_i2s_tx_fifo;
  localparam int DW    = 24;
  localparam int SW    = 32;
  localparam int DP    = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 2*SW*DIV;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 0, rstn = 0, enable = 0;
  logic          s_valid = 0, underrun_clr = 0;
  logic [DW-1:0] s_left = '0, s_right = '0;
  logic          s_ready, underrun, sclk, lrclk, sdout;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  i2s_tx_fifo #(
    .DATA_W(DW), .SLOT_W(SW), .DEPTH(DP), .SCLK_DIV(DIV)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right),
    .level(level), .underrun(underrun),
    .underrun_clr(underrun_clr),
    .sclk(sclk), .lrclk(lrclk), .sdout(sdout)
  );

  always #5 clk = ~clk;

  // Line decoder: position within a slot counted in sclk rises.
  logic [2*DW-1:0] rx_q[$];
  bit              rx_pad[$];
  longint          rx_t[$];
  int              rx_n = 0, rises = 0, idle_cnt = 0, mon_pos = -1;
  logic            mon_lr = 0, mon_ps = 0;
  logic [DW-1:0]   acc_l = '0, acc_r = '0;
  bit              pad_bad = 0;
  longint          t0 = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_ps = 0; mon_lr = 0; mon_pos = -1; idle_cnt = 0;
    end else begin
      if (sclk) idle_cnt = 0;
      else if (idle_cnt < 1000) idle_cnt++;
      if (idle_cnt > DIV) begin
        mon_pos = -1; mon_lr = 0;
      end
      if (sclk && !mon_ps) begin
        rises++;
        if (lrclk != mon_lr) mon_pos = 0;
        else mon_pos++;
        mon_lr = lrclk;
        if (mon_pos == 0 && !lrclk) begin
          t0 = $time; pad_bad = 0; acc_l = '0; acc_r = '0;
        end
        if (mon_pos >= 1 && mon_pos <= DW) begin
          if (lrclk) acc_r = {acc_r[DW-2:0], sdout};
          else acc_l = {acc_l[DW-2:0], sdout};
        end else if (sdout) pad_bad = 1;
        if (lrclk && mon_pos == SW-1) begin
          rx_q.push_back({acc_l, acc_r});
          rx_pad.push_back(!pad_bad);
          rx_t.push_back(t0);
          rx_n++;
        end
      end
      mon_ps = sclk;
    end
  end

  // Model: frames written but not yet sent, in order.
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] last_pop = '0;

  function automatic logic [2*DW-1:0] next_exp();
    if (exp_q.size() > 0) begin
      last_pop = exp_q.pop_front();
      return last_pop;
    end
    return HOLD ? last_pop : '0;
  endfunction

  function automatic logic [2*DW-1:0] rnd_frame();
    return {DW'($urandom), DW'($urandom)};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [2*DW-1:0] f);
    s_valid = 1;
    s_left  = f[2*DW-1:DW];
    s_right = f[DW-1:0];
    tick();
    s_valid = 0;
  endtask

  task automatic wait_rx(output bit ok);
    int n0;
    n0 = rx_n;
    ok = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      tick();
      if (rx_n != n0) begin ok = 1; break; end
    end
  endtask

  task automatic get_rx(output logic [2*DW-1:0] f,
                        output bit pad, output longint t);
    f = 'x; pad = 0; t = 0;
    if (rx_q.size() > 0) begin
      f   = rx_q.pop_front();
      pad = rx_pad.pop_front();
      t   = rx_t.pop_front();
    end
  endtask

  task automatic stop_run(output bit ok);
    enable = 0;
    ok = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      tick();
      if (idle_cnt > 2*DIV) begin ok = 1; break; end
    end
    rx_q.delete(); rx_pad.delete(); rx_t.delete();
  endtask

  task automatic test_reset();
    bit found;
    int r0;
    rstn = 0; tick(3); rstn = 1; tick(2);
    checks++;
    if ({s_ready, level, underrun, sclk, lrclk, sdout}
        !== {1'b1, 3'd0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state rdy %b lvl %0d ur %b sclk %b lr %b sd %b",
               s_ready, level, underrun, sclk, lrclk, sdout);
    end
    drive_push({2{24'hFFFFFF}});
    drive_push({2{24'hFFFFFF}});
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL reset_fill level %0d want 2", level);
    end
    enable = 1;
    found = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      tick();
      if (sclk && lrclk && sdout) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_wait no active output seen want sclk=lr=sd=1");
    end
    rstn = 0;
    #1;
    checks++;
    if ({sclk, lrclk, sdout, underrun, level} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async sclk %b lr %b sd %b lvl %0d want all 0",
               sclk, lrclk, sdout, level);
    end
    enable = 0;
    tick(2); rstn = 1; tick(2);
    checks++;
    if ({s_ready, level} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_release rdy %b lvl %0d want 1 0",
               s_ready, level);
    end
    r0 = rises;
    tick(20);
    checks++;
    if (rises != r0 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle rises %0d sclk %b want 0 0",
               rises - r0, sclk);
    end
    exp_q.delete(); last_pop = '0;
    rx_q.delete(); rx_pad.delete(); rx_t.delete();
  endtask

  task automatic test_basic();
    bit ok, pad;
    logic [2*DW-1:0] got, want;
    longint ta, tb;
    exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    drive_push({24'hA5A5A5, 24'h5A5A5A});
    enable = 1;
    wait_rx(ok);
    get_rx(got, pad, ta);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL basic_frame got %h pad %0d want %h", got, pad, want);
    end
    wait_rx(ok);
    get_rx(got, pad, tb);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL basic_empty got %h pad %0d want %h", got, pad, want);
    end
    checks++;
    if (tb - ta != FRAME*10) begin
      errors++;
      $display("FAIL basic_period got %0d ns want %0d", tb - ta, FRAME*10);
    end
    stop_run(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_stop still running want idle");
    end
  endtask

  task automatic test_underrun();
    bit ok, pad;
    logic [2*DW-1:0] f, got, want;
    longint t;
    underrun_clr = 1; tick(); underrun_clr = 0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_clear got %b want 0", underrun);
    end
    f = rnd_frame();
    exp_q.push_back(f);
    drive_push(f);
    enable = 1;
    wait_rx(ok);
    get_rx(got, pad, t);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL ur_first got %h pad %0d want %h", got, pad, want);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_early got %b want 0", underrun);
    end
    tick();
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_set got %b want 1", underrun);
    end
    wait_rx(ok);
    get_rx(got, pad, t);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL ur_frame got %h pad %0d want %h", got, pad, want);
    end
    underrun_clr = 1; tick(); underrun_clr = 0;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL ur_set_wins got %b want 1", underrun);
    end
    tick(20);
    underrun_clr = 1; tick(); underrun_clr = 0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_mid_clear got %b want 0", underrun);
    end
    wait_rx(ok);
    get_rx(got, pad, t);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL ur_repeat got %h pad %0d want %h", got, pad, want);
    end
    stop_run(ok);
  endtask

  task automatic test_full();
    bit ok, pad, rdy;
    int mlev;
    logic [2*DW-1:0] f, got, want;
    longint t;
    underrun_clr = 1; tick(); underrun_clr = 0;
    mlev = 0;
    for (int i = 0; i < 5; i++) begin
      f = rnd_frame();
      rdy = (mlev != DP);
      s_valid = 1;
      s_left  = f[2*DW-1:DW];
      s_right = f[DW-1:0];
      checks++;
      if (s_ready !== rdy) begin
        errors++;
        $display("FAIL full_ready%0d got %b want %b", i, s_ready, rdy);
      end
      tick();
      s_valid = 0;
      if (rdy) begin exp_q.push_back(f); mlev++; end
      checks++;
      if (level !== 3'(mlev)) begin
        errors++;
        $display("FAIL full_level%0d got %0d want %0d", i, level, mlev);
      end
    end
    enable = 1;
    for (int i = 0; i < DP; i++) begin
      wait_rx(ok);
      get_rx(got, pad, t);
      want = next_exp();
      checks++;
      if (!ok || got !== want || !pad) begin
        errors++;
        $display("FAIL full_order%0d got %h pad %0d want %h",
                 i, got, pad, want);
      end
    end
    stop_run(ok);
    checks++;
    if ({underrun, level} !== 4'd0) begin
      errors++;
      $display("FAIL full_drained ur %b lvl %0d want 0 0", underrun, level);
    end
  endtask

  task automatic test_disable();
    bit ok, pad, found;
    int r0;
    logic [2*DW-1:0] f, got, want;
    longint t;
    for (int i = 0; i < 3; i++) begin
      f = rnd_frame();
      exp_q.push_back(f);
      drive_push(f);
    end
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL dis_fill level %0d want 3", level);
    end
    enable = 1;
    found = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      tick();
      if (mon_lr == 0 && mon_pos == 10) begin found = 1; break; end
    end
    enable = 0;
    wait_rx(ok);
    get_rx(got, pad, t);
    want = next_exp();
    checks++;
    if (!found || !ok || got !== want || !pad) begin
      errors++;
      $display("FAIL dis_complete got %h pad %0d want %h", got, pad, want);
    end
    r0 = rises;
    tick(2*FRAME);
    checks++;
    if (rises != r0 || {sclk, lrclk, sdout} !== 3'b000) begin
      errors++;
      $display("FAIL dis_idle rises %0d sclk %b lr %b want 0 0 0",
               rises - r0, sclk, lrclk);
    end
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL dis_level got %0d want 2", level);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, pad;
    logic [2*DW-1:0] f, got, want;
    longint t;
    for (int i = 0; i < 2; i++) begin
      f = rnd_frame();
      exp_q.push_back(f);
      drive_push(f);
    end
    checks++;
    if ({s_ready, level} !== {1'b0, 3'd4}) begin
      errors++;
      $display("FAIL b2b_full rdy %b lvl %0d want 0 4", s_ready, level);
    end
    enable = 1;
    tick();
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL b2b_entry level %0d want 3", level);
    end
    f = rnd_frame();
    exp_q.push_back(f);
    drive_push(f);
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_refill level %0d want 4", level);
    end
    wait_rx(ok);
    get_rx(got, pad, t);
    want = next_exp();
    checks++;
    if (!ok || got !== want || !pad) begin
      errors++;
      $display("FAIL b2b_first got %h pad %0d want %h", got, pad, want);
    end
    f = rnd_frame();
    s_valid = 1;
    s_left  = f[2*DW-1:DW];
    s_right = f[DW-1:0];
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_refuse rdy %b want 0", s_ready);
    end
    tick();
    checks++;
    if (level !== 3'd3) begin
      errors++;
      $display("FAIL b2b_pop level %0d want 3", level);
    end
    f = rnd_frame();
    s_left  = f[2*DW-1:DW];
    s_right = f[DW-1:0];
    tick();
    s_valid = 0;
    exp_q.push_back(f);
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL b2b_accept level %0d want 4", level);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rx(ok);
      get_rx(got, pad, t);
      want = next_exp();
      checks++;
      if (!ok || got !== want || !pad) begin
        errors++;
        $display("FAIL b2b_order%0d got %h pad %0d want %h",
                 i, got, pad, want);
      end
    end
    stop_run(ok);
    checks++;
    if ({underrun, level} !== 4'd0) begin
      errors++;
      $display("FAIL b2b_end ur %b lvl %0d want 0 0", underrun, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_full();
    test_disable();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
